// File: rtl/pzcorebus_downsizer_request_arbiter.sv
// rtl/pzcorebus_downsizer_request_arbiter.sv - round-robin request arbiter with in-order response routing (optional status: PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN)
module pzcorebus_downsizer_request_arbiter #(
    parameter int REQUESTERS      = 4,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REQUESTERS-1:0] i_command_valid,
    output logic [REQUESTERS-1:0] o_command_ready,
    input  logic [REQUESTERS-1:0] i_command_non_posted,
    input  logic [REQUESTERS-1:0] i_command_with_data,
    input  logic [REQUESTERS-1:0] i_data_valid,
    output logic [REQUESTERS-1:0] o_data_ready,
    input  logic [REQUESTERS-1:0] i_data_last,
    output logic [REQUESTERS-1:0] o_command_select,
    output logic [REQUESTERS-1:0] o_data_select,
    output logic                  o_mcommand_valid,
    input  logic                  i_mcommand_ready,
    output logic                  o_mdata_valid,
    input  logic                  i_mdata_ready,
    input  logic                  i_mresponse_valid,
    output logic                  o_mresponse_ready,
    input  logic                  i_mresponse_last,
    output logic [REQUESTERS-1:0] o_response_valid,
    input  logic [REQUESTERS-1:0] i_response_ready,
    output logic [REQUESTERS-1:0] o_response_select,
    output logic                  o_busy
`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
    ,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] o_outstanding,
    output logic                                 o_error
`endif
);
    localparam int GW = $clog2(REQUESTERS);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t          state;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   rr_ptr;
    logic [REQUESTERS-1:0] grant_onehot;

    logic            arb_found;
    logic [GW-1:0]   arb_index;

    logic [GW-1:0]   fifo_mem [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            fifo_empty;
    logic            fifo_full;
    logic [GW-1:0]   head;
    logic [REQUESTERS-1:0] head_onehot;

    logic            in_cmd;
    logic            in_data;
    logic            cmd_fire;
    logic            data_last_fire;
    logic            push;
    logic            pop;

    // Requester index offset from a base, wrapping at REQUESTERS (which need not be a power of 2).
    function automatic logic [GW-1:0] wrap_add(input logic [GW-1:0] base, input int unsigned offset);
        int unsigned sum;
        sum = 32'(base) + offset;
        if (sum >= 32'(REQUESTERS)) begin
            sum = sum - 32'(REQUESTERS);
        end
        return GW'(sum);
    endfunction

    // First valid requester at or above the round-robin pointer, with wrap.
    always_comb begin
        arb_found = 1'b0;
        arb_index = '0;
        for (int k = 0; k < REQUESTERS; k++) begin
            if (!arb_found && i_command_valid[wrap_add(rr_ptr, 32'(k))]) begin
                arb_found = 1'b1;
                arb_index = wrap_add(rr_ptr, 32'(k));
            end
        end
    end

    assign grant_onehot = REQUESTERS'(1) << grant;
    assign in_cmd       = (state == CMD);
    assign in_data      = (state == DATA);

    assign o_command_select = in_cmd ? grant_onehot : '0;
    assign o_mcommand_valid = in_cmd && i_command_valid[grant];
    assign o_command_ready  = (in_cmd && i_mcommand_ready) ? grant_onehot : '0;

    assign o_data_select = in_data ? grant_onehot : '0;
    assign o_mdata_valid = in_data && i_data_valid[grant];
    assign o_data_ready  = (in_data && i_mdata_ready) ? grant_onehot : '0;

    assign cmd_fire       = o_mcommand_valid && i_mcommand_ready;
    assign data_last_fire = o_mdata_valid && i_mdata_ready && i_data_last[grant];

    assign fifo_empty  = (count == '0);
    assign fifo_full   = (count == CW'(MAX_OUTSTANDING));
    assign head        = fifo_mem[rd_ptr];
    assign head_onehot = REQUESTERS'(1) << head;

    assign push = cmd_fire && i_command_non_posted[grant];
    assign pop  = !fifo_empty && i_mresponse_valid && i_response_ready[head] && i_mresponse_last;

    assign o_response_select = fifo_empty ? '0 : head_onehot;
    assign o_response_valid  = (!fifo_empty && i_mresponse_valid) ? head_onehot : '0;
    assign o_mresponse_ready = !fifo_empty && i_response_ready[head];

    assign o_busy = (state != IDLE) || !fifo_empty;

    // Command FSM: the grant is held from arbitration through the end of the write burst.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_found && !fifo_full) begin
                        grant <= arb_index;
                        state <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_fire) begin
                        rr_ptr <= wrap_add(grant, 32'd1);
                        state  <= i_command_with_data[grant] ? DATA : IDLE;
                    end
                end
                DATA: begin
                    if (data_last_fire) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Response-routing FIFO storage; contents are meaningless while count is 0.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= grant;
        end
    end

    // Response-routing FIFO pointers and occupancy; push and pop together keep the count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
    assign o_outstanding = count;

    // Sticky flag for a response arriving with nothing outstanding.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_error <= 1'b0;
        end else if (i_mresponse_valid && fifo_empty) begin
            o_error <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pzcorebus_downsizer_request_arbiter.sv
// tb/tb_pzcorebus_downsizer_request_arbiter.sv - self-checking bench for pzcorebus_downsizer_request_arbiter
module tb_pzcorebus_downsizer_request_arbiter;
    localparam int R = 4;
    localparam int M = 8;

    logic clk = 1'b0;
    logic rst;
    logic [R-1:0] cv, cr, np, wd, dv, dr, dl, csel, dsel, rv, rrdy, rsel;
    logic mcv, mcr, mdv, mdr, mrv, mrr, mlast, busy;
`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
    logic [3:0] outstanding;
    logic       err;
`endif

    always #5 clk = ~clk;

    pzcorebus_downsizer_request_arbiter #(
        .REQUESTERS      (R),
        .MAX_OUTSTANDING (M)
    ) dut (
        .i_clk                (clk),
        .i_rst                (rst),
        .i_command_valid      (cv),
        .o_command_ready      (cr),
        .i_command_non_posted (np),
        .i_command_with_data  (wd),
        .i_data_valid         (dv),
        .o_data_ready         (dr),
        .i_data_last          (dl),
        .o_command_select     (csel),
        .o_data_select        (dsel),
        .o_mcommand_valid     (mcv),
        .i_mcommand_ready     (mcr),
        .o_mdata_valid        (mdv),
        .i_mdata_ready        (mdr),
        .i_mresponse_valid    (mrv),
        .o_mresponse_ready    (mrr),
        .i_mresponse_last     (mlast),
        .o_response_valid     (rv),
        .i_response_ready     (rrdy),
        .o_response_select    (rsel),
        .o_busy               (busy)
`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
        ,
        .o_outstanding        (outstanding),
        .o_error              (err)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = waiting to arbitrate, 1 = offering owner's command, 2 = owner's burst.
    int ph = 0;
    int own = 0;
    int rrp = 0;
    int q[$];
    bit merr = 0;

    // Values sampled mid-cycle for the directed scenarios.
    logic [R-1:0] s_csel, s_dsel, s_rsel;
    logic s_cfire, s_dfire, s_pop, s_mrr, s_mcv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_check();
        logic [R-1:0] oh, hoh, e_rsel, e_rv;
        logic e_mrr;
        oh = R'(1) << own;
        e_rsel = '0;
        e_rv = '0;
        e_mrr = 1'b0;
        if (q.size() > 0) begin
            hoh = R'(1) << q[0];
            e_rsel = hoh;
            e_rv = mrv ? hoh : '0;
            e_mrr = rrdy[q[0]];
        end
        chk("command_select", csel, (ph == 1) ? oh : '0);
        chk("mcommand_valid", mcv, (ph == 1) && cv[own]);
        chk("command_ready", cr, (ph == 1 && mcr) ? oh : '0);
        chk("data_select", dsel, (ph == 2) ? oh : '0);
        chk("mdata_valid", mdv, (ph == 2) && dv[own]);
        chk("data_ready", dr, (ph == 2 && mdr) ? oh : '0);
        chk("response_select", rsel, e_rsel);
        chk("response_valid", rv, e_rv);
        chk("mresponse_ready", mrr, e_mrr);
        chk("busy", busy, (ph != 0) || (q.size() != 0));
`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
        chk("outstanding", outstanding, q.size());
        chk("error", err, merr);
`endif
    endtask

    task automatic model_update();
        int n0;
        bit popped;
        bit found;
        if (rst) begin
            ph = 0; own = 0; rrp = 0; merr = 0;
            q.delete();
            return;
        end
        n0 = q.size();
        popped = (n0 > 0) && mrv && rrdy[q[0]] && mlast;
        if (mrv && n0 == 0) merr = 1;
        case (ph)
            0: if (cv != 0 && n0 < M) begin
                found = 0;
                for (int k = 0; k < R; k++) begin
                    if (!found && cv[(rrp + k) % R]) begin
                        found = 1;
                        own = (rrp + k) % R;
                    end
                end
                ph = 1;
            end
            1: if (cv[own] && mcr) begin
                if (np[own]) q.push_back(own);
                rrp = (own + 1) % R;
                ph = wd[own] ? 2 : 0;
            end
            default: if (dv[own] && mdr && dl[own]) ph = 0;
        endcase
        if (popped) void'(q.pop_front());
    endtask

    // One clock: check outputs after inputs settle, advance the model at the edge, return at negedge.
    task automatic tick();
        #1;
        s_csel = csel; s_dsel = dsel; s_rsel = rsel;
        s_cfire = mcv & mcr; s_dfire = |(dr & dv); s_pop = mrv & mrr & mlast;
        s_mrr = mrr; s_mcv = mcv;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        cv = '0; np = '0; wd = '0; dv = '0; dl = '0; rrdy = '0;
        mcr = 0; mdr = 0; mrv = 0; mlast = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        logic [R-1:0] grants[$];
        logic [R-1:0] exp_rsel[3];
        int n, beats, cyc, last_cyc, first3, reqs[3];

        rst = 1;
        clear_inputs();
        @(negedge clk);
        do_reset();
        chk("reset_busy", busy, 0);
        chk("reset_mresponse_ready", mrr, 0);

        // Rotation between requesters 0 and 2.
        cv = 4'b0101; mcr = 1;
        tick();
        chk("rot_latency_idle", s_mcv, 0);
        tick();
        chk("rot_latency_cmd", s_mcv, 1);
        if (s_cfire) grants.push_back(s_csel);
        for (int t = 0; t < 20 && grants.size() < 4; t++) begin
            tick();
            if (s_cfire) grants.push_back(s_csel);
        end
        chk("rot_count", grants.size(), 4);
        for (int i = 0; i < 4 && i < grants.size(); i++) chk("rot_grant", grants[i], (i % 2 == 0) ? 4'b0001 : 4'b0100);

        // Write lock: requester 1 bursts 4 beats while requester 3 waits.
        do_reset();
        cv = 4'b1010; wd = 4'b0010; dv = 4'b0010; mcr = 1; mdr = 1;
        beats = 0; cyc = 0; last_cyc = -10; first3 = -1;
        for (int t = 0; t < 40 && first3 < 0; t++) begin
            dl = (beats == 3) ? 4'b0010 : 4'b0000;
            tick();
            if (s_cfire && s_csel == 4'b0010) cv[1] = 0;
            if (s_dfire) begin
                chk("lock_data_select", s_dsel, 4'b0010);
                beats++;
                if (beats == 4) last_cyc = cyc;
            end
            if (s_csel == 4'b1000 && first3 < 0) first3 = cyc;
            cyc++;
        end
        chk("lock_beats", beats, 4);
        chk("lock_grant3_timing", first3, last_cyc + 2);

        // Outstanding limit: the 9th non-posted command waits for a freed slot.
        do_reset();
        cv = 4'b0001; np = 4'b0001; mcr = 1;
        n = 0;
        for (int t = 0; t < 40; t++) begin
            tick();
            if (s_cfire) n++;
        end
        chk("limit_accepted", n, 8);
        mrv = 1; mlast = 1; rrdy = 4'b1111;
        tick();
        chk("limit_pop", s_pop, 1);
        mrv = 0;
        n = 0;
        for (int t = 0; t < 10 && n == 0; t++) begin
            tick();
            if (s_cfire) n++;
        end
        chk("limit_ninth", n, 1);

        // Response routing order 2,0,3 with a stall on requester 0.
        do_reset();
        np = 4'b1111; mcr = 1;
        reqs[0] = 2; reqs[1] = 0; reqs[2] = 3;
        for (int i = 0; i < 3; i++) begin
            cv = R'(1) << reqs[i];
            n = 0;
            for (int t = 0; t < 10 && n == 0; t++) begin
                tick();
                if (s_cfire) begin
                    n = 1;
                    chk("route_cmd_select", s_csel, R'(1) << reqs[i]);
                end
            end
            chk("route_cmd_fire", n, 1);
            cv = '0;
        end
        exp_rsel[0] = 4'b0100; exp_rsel[1] = 4'b0001; exp_rsel[2] = 4'b1000;
        mrv = 1; mlast = 1;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                rrdy = 4'b1110;
                for (int t = 0; t < 2; t++) begin
                    tick();
                    chk("route_stall_ready", s_mrr, 0);
                    chk("route_stall_select", s_rsel, 4'b0001);
                end
            end
            rrdy = 4'b1111;
            tick();
            chk("route_select", s_rsel, exp_rsel[i]);
            chk("route_pop", s_pop, 1);
        end
        mrv = 0;
        tick();
        chk("route_drained", s_rsel, 0);

        // Simultaneous push and pop.
        do_reset();
        np = 4'b1111; mcr = 1; cv = 4'b0010;
        n = 0;
        for (int t = 0; t < 10 && n == 0; t++) begin
            tick();
            if (s_cfire) n = 1;
        end
        chk("pp_first_fire", n, 1);
        cv = 4'b0100;
        tick();
        mrv = 1; mlast = 1; rrdy = 4'b1111;
        tick();
        chk("pp_cmd_fire", s_cfire, 1);
        chk("pp_pop", s_pop, 1);
        chk("pp_old_head", s_rsel, 4'b0010);
        mrv = 0; cv = '0;
        tick();
        chk("pp_new_head", s_rsel, 4'b0100);
`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
        chk("pp_count", outstanding, 1);
`endif

        // Reset during beat 2 of a burst.
        do_reset();
        cv = 4'b0001; wd = 4'b0001; dv = 4'b0001; mcr = 1; mdr = 1;
        beats = 0;
        for (int t = 0; t < 10 && beats == 0; t++) begin
            tick();
            if (s_cfire) cv = '0;
            if (s_dfire) beats++;
        end
        chk("rst_first_beat", beats, 1);
        rst = 1;
        tick();
        rst = 0; dv = '0;
        tick();
        chk("rst_zero_outputs", {csel, dsel, cr, dr, rv, rsel, mcv, mdv, mrr, busy}, 0);
        mrv = 1;
        tick();
        mrv = 0;
        tick();
`ifdef PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN
        chk("rst_error_sticky", err, 1);
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int t = 0; t < 600; t++) begin
            cv = R'($urandom); np = R'($urandom); wd = R'($urandom);
            dv = R'($urandom); dl = R'($urandom); rrdy = R'($urandom);
            mcr = 1'($urandom); mdr = 1'($urandom);
            mrv = 1'($urandom); mlast = 1'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pzcorebus_downsizer_request_arbiter.md
Name:
pzcorebus_downsizer_request_arbiter

Overview:
- Shares one downsizer slave port between REQUESTERS corebus masters.
- Round-robin arbitration of commands. The grant is locked through the write-data burst of the winning command.
- Non-posted responses are routed back in order through an internal grant-index FIFO.
- Control-only block: it drives the valid/ready handshakes and one-hot selects. Payload muxing is done outside this block using the select outputs.

Parameters:
- REQUESTERS, 4, number of requesters (2..16).
- MAX_OUTSTANDING, 8, depth of the response-routing FIFO (power of 2, ≥2).

Ports:
- i_clk  input  1  clock
- i_rst  input  1  synchronous active-high reset
- i_command_valid  input  REQUESTERS  per-requester command valid
- o_command_ready  output  REQUESTERS  per-requester command ready
- i_command_non_posted  input  REQUESTERS  command expects a response
- i_command_with_data  input  REQUESTERS  command carries write data
- i_data_valid  input  REQUESTERS  per-requester write-data valid
- o_data_ready  output  REQUESTERS  per-requester write-data ready
- i_data_last  input  REQUESTERS  per-requester last data beat
- o_command_select  output  REQUESTERS  one-hot command payload select
- o_data_select  output  REQUESTERS  one-hot data payload select
- o_mcommand_valid  output  1  command valid toward downsizer
- i_mcommand_ready  input  1  downsizer command ready
- o_mdata_valid  output  1  data valid toward downsizer
- i_mdata_ready  input  1  downsizer data ready
- i_mresponse_valid  input  1  downsizer response valid
- o_mresponse_ready  output  1  response ready toward downsizer
- i_mresponse_last  input  1  last response beat
- o_response_valid  output  REQUESTERS  routed response valid
- i_response_ready  input  REQUESTERS  requester response ready
- o_response_select  output  REQUESTERS  one-hot response payload select
- o_busy  output  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE, rr pointer=0, grant=0, FIFO empty.
  - All valid, ready and select outputs are 0; o_busy=0.
- FSM states are IDLE, CMD and DATA.
- IDLE:
  - All command and data readies are 0.
  - If any i_command_valid is set and FIFO count < MAX_OUTSTANDING, pick the first valid requester searching upward from the rr pointer with wrap.
  - Register that requester as the grant and go to CMD.
  - Requester-valid to o_mcommand_valid latency is 1 cycle.
- CMD:
  - o_command_select = onehot(grant).
  - o_mcommand_valid = i_command_valid[grant].
  - o_command_ready[grant] = i_mcommand_ready; all other command readies are 0.
  - On handshake:
    - If non_posted[grant], push grant into the FIFO.
    - rr pointer = grant+1 mod REQUESTERS.
    - If with_data[grant], go to DATA; else go to IDLE.
  - The grant never changes while in CMD, even if the granted requester drops valid (protocol violation: it simply stalls).
- DATA:
  - o_data_select = onehot(grant).
  - o_mdata_valid = i_data_valid[grant].
  - o_data_ready[grant] = i_mdata_ready.
  - A handshake with i_data_last[grant]=1 returns to IDLE.
  - Other requesters' data is never accepted.
- Sustained throughput is at most one command per 2 cycles (IDLE->CMD), plus data beats.
- FIFO space check:
  - Arbitration checks space in IDLE, so the CMD push always has room.
  - A simultaneous push and pop leaves the count unchanged.
- Response path (independent of the FSM):
  - If the FIFO is non-empty with head h:
    - o_response_select = onehot(h).
    - o_response_valid[h] = i_mresponse_valid.
    - o_mresponse_ready = i_response_ready[h].
    - A handshake with i_mresponse_last pops the head.
  - If the FIFO is empty: o_mresponse_ready=0, all o_response_valid=0, o_response_select=0.
- Reset mid-burst:
  - Aborts immediately; all state returns to the reset values.
  - Outstanding routing is lost; upstream must be reset together.

Optional Feature:
- Macro: PZCOREBUS_DOWNSIZER_ARBITER_STATUS_EN.
- When defined, two extra outputs are added:
  - o_outstanding, width $clog2(MAX_OUTSTANDING+1): current FIFO count, registered, reset 0.
  - o_error, 1 bit: sticky, set when i_mresponse_valid=1 while the FIFO is empty. Cleared only by reset.
- When undefined, neither port exists and the behaviour is otherwise identical.

Test Plan:
- Rotation: requesters 0 and 2 assert posted no-data commands continuously, i_mcommand_ready=1.
  - Required: grants 0,2,0,2; o_mcommand_valid high on alternating cycles, starting 1 cycle after the first valid.
- Write lock: requester 1 issues a with_data command with 4 data beats while requester 3 holds command valid.
  - Required: o_data_select=0b0010 for all 4 beats.
  - Required: requester 3 is granted only in the cycle after the last beat handshake (return to IDLE).
- Outstanding limit: MAX_OUTSTANDING=8, 8 non-posted commands accepted, no responses returned.
  - Required: a 9th command is never granted.
  - Required: one response with last=1 frees one slot and the 9th command is then granted.
- Response routing: non-posted commands are granted in order 2,0,3, then 3 responses arrive, each with last=1.
  - Required: o_response_select is 0b0100, then 0b0001, then 0b1000.
  - Required: i_response_ready[0]=0 stalls o_mresponse_ready for exactly those cycles.
- Simultaneous push/pop: with the FIFO holding 1 entry, a non-posted command handshake and a last-response handshake occur in the same cycle.
  - Required: count stays 1 and the new head is the new grant.
- Reset mid-burst: assert i_rst during DATA beat 2.
  - Required: the next cycle has all outputs 0 and state IDLE.
  - Required (STATUS_EN): a response arriving after reset sets o_error=1.
